// File: rtl/fft16_input_packer.sv
// Collects a 16-sample complex frame from a serial stream into one of two banks (ping-pong).
// Presents the read bank in parallel; a frame is valid the cycle after its 16th sample is accepted.
module fft16_input_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int N_POINT    = 16
) (
  input  logic                           sys_clk_i,
  input  logic                           rst_i,
  input  logic                           din_valid_i,
  output logic                           din_ready_o,
  input  logic                           din_sop_i,
  input  logic signed [DATA_WIDTH-1:0]   din_real_i,
  input  logic signed [DATA_WIDTH-1:0]   din_imag_i,
  output logic                           frame_valid_o,
  input  logic                           frame_ready_i,
  output logic [DATA_WIDTH*N_POINT-1:0]  xn_real_o,
  output logic [DATA_WIDTH*N_POINT-1:0]  xn_imag_o,
  output logic                           sync_err_o
);

  typedef enum logic {HUNT, FILL} state_t;

  localparam logic [3:0] LAST_IDX = 4'(N_POINT - 1);

  state_t     state, state_nxt;
  logic [3:0] wr_idx, idx_nxt, wr_addr;
  logic       wr_bank, rd_bank;
  logic [1:0] full;
  logic       accept, consume, wr_en, complete, err_nxt;

  logic [DATA_WIDTH-1:0] bank_re [2][N_POINT];
  logic [DATA_WIDTH-1:0] bank_im [2][N_POINT];

  assign din_ready_o   = ~full[wr_bank];
  assign frame_valid_o = full[rd_bank];
  assign accept        = din_valid_i & din_ready_o;
  assign consume       = frame_valid_o & frame_ready_i;

  always_comb begin
    state_nxt = state;
    idx_nxt   = wr_idx;
    wr_addr   = wr_idx;
    wr_en     = 1'b0;
    complete  = 1'b0;
    err_nxt   = 1'b0;
    if (accept) begin
      if (din_sop_i) begin
        // A sop always restarts the frame; in FILL it also flags the lost partial frame.
        err_nxt   = (state == FILL);
        wr_en     = 1'b1;
        wr_addr   = 4'd0;
        idx_nxt   = 4'd1;
        state_nxt = FILL;
      end else if (state == HUNT) begin
        err_nxt = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (wr_idx == LAST_IDX) begin
          complete  = 1'b1;
          idx_nxt   = 4'd0;
          state_nxt = HUNT;
        end else begin
          idx_nxt = wr_idx + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state      <= HUNT;
      wr_idx     <= 4'd0;
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      full       <= 2'b00;
      sync_err_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_idx     <= idx_nxt;
      sync_err_o <= err_nxt;
      // complete targets an empty bank and consume a full one, so they never collide.
      if (complete) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (wr_en) begin
      bank_re[wr_bank][wr_addr] <= din_real_i;
      bank_im[wr_bank][wr_addr] <= din_imag_i;
    end
  end

  always_comb begin
    xn_real_o = '0;
    xn_imag_o = '0;
    for (int k = 0; k < N_POINT; k++) begin
      xn_real_o[DATA_WIDTH*k +: DATA_WIDTH] = bank_re[rd_bank][k];
      xn_imag_o[DATA_WIDTH*k +: DATA_WIDTH] = bank_im[rd_bank][k];
    end
  end

endmodule
